// File: rtl/t10_keypad_pkg.sv
// Shared types and key codes for the 4x4 keypad scanner and the letter FSM.
package t10_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Key codes are {row one-hot, col one-hot}.
    localparam logic [7:0] KEY_SUBMIT_LETTER = 8'h18;
    localparam logic [7:0] KEY_CLEAR         = 8'h14;
    localparam logic [7:0] KEY_SUBMIT_WORD   = 8'h12;
    localparam logic [7:0] KEY_GAME_END      = 8'h21;
    localparam logic [7:0] KEY_INVALID_R0C0  = 8'h88;
    localparam logic [7:0] KEY_INVALID_R0C3  = 8'h81;
    localparam logic [7:0] KEY_INVALID_R1C3  = 8'h41;
    localparam logic [7:0] KEY_INVALID_R3C3  = 8'h11;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/t10_keypad_scanner_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous inputs.
module t10_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/t10_keypad_scanner.sv
// Row-scanning keypad front end: drives rows, debounces column returns and
// presents one accepted key as a one-hot {row, col} byte plus a hold strobe.
module t10_keypad_scanner
    import t10_keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 100,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_col_in,
    output logic [3:0] o_row_drive,
    output logic [7:0] o_cur_key,
    output logic       o_strobe
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic [CNT_W-1:0] lim);
        return (c >= lim) ? lim : c + CNT_W'(1);
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] r);
        return {r[0], r[3:1]};
    endfunction

    logic [3:0]  w_col_sync;
    scan_state_t r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]  r_cand;
    logic [3:0]  r_row;
    logic [7:0]  r_key;
    logic        r_strobe;

    t10_sync2 #(.WIDTH(4)) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_col_in),
        .o_q   (w_col_sync)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= SCAN;
            r_cnt    <= '0;
            r_cand   <= 8'h00;
            r_row    <= 4'b1000;
            r_key    <= 8'h00;
            r_strobe <= 1'b0;
        end else begin
            case (r_state)
                SCAN: begin
                    // Columns are only trusted at the end of a row period,
                    // once the synchronizer has caught up with the new row.
                    if (r_cnt == SCAN_LAST) begin
                        r_cnt <= '0;
                        if (is_onehot4(w_col_sync)) begin
                            r_cand  <= {r_row, w_col_sync};
                            r_state <= DEBOUNCE;
                        end else begin
                            r_row <= next_row(r_row);
                        end
                    end else begin
                        r_cnt <= sat_inc(r_cnt, SCAN_LAST);
                    end
                end
                DEBOUNCE: begin
                    if (w_col_sync != r_cand[3:0]) begin
                        r_state <= SCAN;
                        r_row   <= next_row(r_row);
                        r_cnt   <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state  <= PRESSED;
                        r_key    <= r_cand;
                        r_strobe <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt, DEB_LAST);
                    end
                end
                PRESSED: begin
                    if (w_col_sync != r_cand[3:0]) begin
                        r_state  <= RELEASE;
                        r_strobe <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RELEASE: begin
                    // Key code stays valid through the release debounce so the
                    // consumer can still sample it after the strobe falls.
                    if (w_col_sync != 4'd0) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_LAST) begin
                        r_state <= SCAN;
                        r_key   <= 8'h00;
                        r_row   <= next_row(r_row);
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= sat_inc(r_cnt, DEB_LAST);
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign o_row_drive = r_row;
    assign o_cur_key   = r_key;
    assign o_strobe    = r_strobe;

endmodule
